// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, cache and statistics signals of the memory-port arbiter
interface mem_port_arbiter_if #(parameter int CNT_W = 16);
  logic             i_req, d_req, d_wr, i_ack, d_ack, hit, i_stall, d_stall;
  logic [15:0]      i_addr, d_addr, d_wdata, rdata;
  logic             cache_rd, cache_wr, cache_done, cache_hit, cache_stall;
  logic [15:0]      cache_addr, cache_wdata, cache_rdata;
  logic [CNT_W-1:0] acc_cnt, hit_cnt;
  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
    input  cache_done, cache_hit, cache_stall, cache_rdata,
    output i_ack, d_ack, rdata, hit, i_stall, d_stall,
    output cache_rd, cache_wr, cache_addr, cache_wdata, acc_cnt, hit_cnt
  );
  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
    output cache_done, cache_hit, cache_stall, cache_rdata,
    input  i_ack, d_ack, rdata, hit, i_stall, d_stall,
    input  cache_rd, cache_wr, cache_addr, cache_wdata, acc_cnt, hit_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one cache controller between the I-fetch and D-memory ports
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t           state_q;
  logic             owner_q, wr_q, i_ack_q, d_ack_q, hit_q, cache_rd_q, cache_wr_q;
  logic [3:0]       streak_q;
  logic [15:0]      addr_q, wdata_q, rdata_q;
  logic [CNT_W-1:0] acc_q, hits_q;
  logic             grant_i;
  // D normally wins; I is forced through once D has won STARVE_MAX times in a row over it
  assign grant_i = bus.i_req && (!bus.d_req || streak_q == 4'(STARVE_MAX));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      wr_q       <= 1'b0;
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      hit_q      <= 1'b0;
      cache_rd_q <= 1'b0;
      cache_wr_q <= 1'b0;
      streak_q   <= 4'd0;
      addr_q     <= 16'd0;
      wdata_q    <= 16'd0;
      rdata_q    <= 16'd0;
      acc_q      <= '0;
      hits_q     <= '0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        IDLE: if (!bus.cache_stall && (bus.i_req || bus.d_req)) begin
          state_q    <= BUSY;
          owner_q    <= !grant_i;
          wr_q       <= !grant_i && bus.d_wr;
          cache_rd_q <= grant_i || !bus.d_wr;
          cache_wr_q <= !grant_i && bus.d_wr;
          addr_q     <= grant_i ? bus.i_addr : bus.d_addr;
          if (!grant_i && bus.d_wr) wdata_q <= bus.d_wdata;
          streak_q   <= (!grant_i && bus.i_req) ? streak_q + 4'd1 : 4'd0;
        end
        // direction stays asserted until Done: the cache re-samples it while filling
        BUSY: if (bus.cache_done) begin
          state_q    <= RESP;
          cache_rd_q <= 1'b0;
          cache_wr_q <= 1'b0;
          hit_q      <= bus.cache_hit;
          if (!wr_q) rdata_q <= bus.cache_rdata;
          i_ack_q    <= !owner_q;
          d_ack_q    <= owner_q;
        end
        RESP: begin
          state_q <= IDLE;
          acc_q   <= acc_q + CNT_W'(~&acc_q);
          hits_q  <= hits_q + CNT_W'(hit_q & ~&hits_q);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.i_ack       = i_ack_q;
  assign bus.d_ack       = d_ack_q;
  assign bus.rdata       = rdata_q;
  assign bus.hit         = hit_q;
  assign bus.i_stall     = bus.i_req & ~i_ack_q;
  assign bus.d_stall     = bus.d_req & ~d_ack_q;
  assign bus.cache_rd    = cache_rd_q;
  assign bus.cache_wr    = cache_wr_q;
  assign bus.cache_addr  = addr_q;
  assign bus.cache_wdata = wdata_q;
  assign bus.acc_cnt     = acc_q;
  assign bus.hit_cnt     = hits_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int SM = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.CNT_W(16)) b ();
  mem_port_arbiter_if #(.CNT_W(4))  s ();
  mem_port_arbiter #(.STARVE_MAX(SM), .CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(b.slave));
  mem_port_arbiter #(.STARVE_MAX(SM), .CNT_W(4))  dut_s (.clk(clk), .rst(rst), .bus(s.slave));
  assign s.i_req       = b.i_req;
  assign s.i_addr      = b.i_addr;
  assign s.d_req       = b.d_req;
  assign s.d_wr        = b.d_wr;
  assign s.d_addr      = b.d_addr;
  assign s.d_wdata     = b.d_wdata;
  assign s.cache_done  = b.cache_done;
  assign s.cache_hit   = b.cache_hit;
  assign s.cache_stall = b.cache_stall;
  assign s.cache_rdata = b.cache_rdata;
  int errors = 0, checks = 0;
  bit in_txn, ack_due, t_own, t_wr, exp_hit, g_own, g_wr, i_rel, d_rel, cm_h, force_rd_en;
  logic [15:0] t_addr, t_wdata, g_addr, g_wdata, exp_rdata, force_rd;
  int acc_m, hit_m, streak_m, mode, cm_left, cm_cool, force_lat;
  bit glog[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int sat(input int v, input int w);
    return v > (1 << w) - 1 ? (1 << w) - 1 : v;
  endfunction
  task automatic mreset();
    in_txn = 0; ack_due = 0; exp_hit = 0; exp_rdata = 16'd0;
    acc_m = 0; hit_m = 0; streak_m = 0; cm_left = 0; cm_cool = 0;
    i_rel = 0; d_rel = 0;
    b.cache_done = 0; b.cache_hit = 0; b.cache_stall = 0; b.cache_rdata = 16'd0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_i_ack"}, b.i_ack, 0);
    chk({tag, "_d_ack"}, b.d_ack, 0);
    chk({tag, "_rdata"}, b.rdata, 0);
    chk({tag, "_hit"}, b.hit, 0);
    chk({tag, "_cache_rd"}, b.cache_rd, 0);
    chk({tag, "_cache_wr"}, b.cache_wr, 0);
    chk({tag, "_cache_addr"}, b.cache_addr, 0);
    chk({tag, "_cache_wdata"}, b.cache_wdata, 0);
    chk({tag, "_acc_cnt"}, b.acc_cnt, 0);
    chk({tag, "_hit_cnt"}, b.hit_cnt, 0);
  endtask
  task automatic new_i();
    b.i_req = 1; b.i_addr = 16'($urandom);
  endtask
  task automatic new_d();
    b.d_req = 1; b.d_wr = 1'($urandom); b.d_addr = 16'($urandom); b.d_wdata = 16'($urandom);
  endtask
  task automatic tick();
    bit act, resp, done_now, elig, win_i, cap_hit;
    logic [15:0] cap_rd;
    int lat;
    act = in_txn && !ack_due;
    resp = ack_due;
    done_now = act && b.cache_done;
    cap_hit = b.cache_hit;
    cap_rd = b.cache_rdata;
    elig = !in_txn && !b.cache_stall && (b.i_req || b.d_req);
    win_i = b.i_req && (!b.d_req || streak_m == SM);
    if (elig) begin
      g_own = !win_i; g_wr = !win_i && b.d_wr;
      g_addr = win_i ? b.i_addr : b.d_addr; g_wdata = b.d_wdata;
      streak_m = (!win_i && b.i_req) ? streak_m + 1 : 0;
    end
    @(posedge clk); #1;
    if (resp) begin in_txn = 0; acc_m++; hit_m += int'(exp_hit); end
    ack_due = done_now;
    if (done_now) begin exp_hit = cap_hit; if (!t_wr) exp_rdata = cap_rd; end
    if (elig) begin
      in_txn = 1; t_own = g_own; t_wr = g_wr; t_addr = g_addr; t_wdata = g_wdata;
      glog.push_back(g_own);
    end
    act = in_txn && !ack_due;
    chk("i_ack", b.i_ack, ack_due && !t_own);
    chk("d_ack", b.d_ack, ack_due && t_own);
    chk("i_stall", b.i_stall, b.i_req && !(ack_due && !t_own));
    chk("d_stall", b.d_stall, b.d_req && !(ack_due && t_own));
    chk("cache_rd", b.cache_rd, act && !t_wr);
    chk("cache_wr", b.cache_wr, act && t_wr);
    if (act) chk("cache_addr", b.cache_addr, t_addr);
    if (act && t_wr) chk("cache_wdata", b.cache_wdata, t_wdata);
    if (ack_due) begin chk("rdata", b.rdata, exp_rdata); chk("hit", b.hit, exp_hit); end
    chk("acc_cnt", b.acc_cnt, sat(acc_m, 16));
    chk("hit_cnt", b.hit_cnt, sat(hit_m, 16));
    chk("acc_cnt4", s.acc_cnt, sat(acc_m, 4));
    chk("hit_cnt4", s.hit_cnt, sat(hit_m, 4));
    // cache model: hit = done 2 cycles after request, clean miss 6, dirty miss 10
    b.cache_rdata = 16'($urandom);
    b.cache_hit = 1'($urandom);
    b.cache_done = 0;
    if (cm_left > 0) begin
      cm_left--;
      if (cm_left == 0) begin
        b.cache_done = 1; b.cache_hit = cm_h;
        if (force_rd_en) b.cache_rdata = force_rd;
        cm_cool = force_lat > 0 ? 0 : int'($urandom_range(0, 3));
      end
    end else if (cm_cool > 0) cm_cool--;
    else if (b.cache_rd || b.cache_wr) begin
      lat = $urandom_range(0, 3);
      lat = force_lat > 0 ? force_lat : (lat < 2 ? 2 : (lat == 2 ? 6 : 10));
      cm_left = lat; cm_h = lat == 2;
    end
    b.cache_stall = cm_left > 0 || b.cache_done || cm_cool > 0;
    if (!act && mode == 0 && $urandom_range(0, 7) == 0) b.cache_done = 1;
    if (mode != 2) begin
      if (i_rel) begin
        i_rel = 0;
        if (mode == 1 || (mode == 0 && $urandom_range(0, 1) == 1)) new_i(); else b.i_req = 0;
      end else if (!b.i_req && (mode == 1 || (mode == 0 && $urandom_range(0, 3) == 0))) new_i();
      if (d_rel) begin
        d_rel = 0;
        if (mode == 1 || (mode == 0 && $urandom_range(0, 1) == 1)) new_d(); else b.d_req = 0;
      end else if (!b.d_req && (mode == 1 || (mode == 0 && $urandom_range(0, 3) == 0))) new_d();
      if (mode == 0 && act && $urandom_range(0, 2) == 0) begin
        if (t_own) begin b.d_addr = 16'($urandom); b.d_wdata = 16'($urandom); end
        else b.i_addr = 16'($urandom);
      end
      if (ack_due) begin if (t_own) d_rel = 1; else i_rel = 1; end
    end
  endtask
  task automatic wait_ack(output int n);
    n = 0;
    do begin tick(); n++; end while (!b.i_ack && !b.d_ack && n < 40);
  endtask
  task automatic drain();
    int n;
    mode = 3; n = 0;
    while ((in_txn || b.i_req || b.d_req) && n < 400) begin tick(); n++; end
    chk("drain_done", n < 400, 1);
  endtask
  initial begin
    int n;
    mode = 2; force_lat = 0; force_rd_en = 0; force_rd = 16'd0;
    b.i_req = 0; b.i_addr = 16'd0; b.d_req = 0; b.d_wr = 0; b.d_addr = 16'd0; b.d_wdata = 16'd0;
    mreset();
    repeat (2) @(posedge clk);
    #1 chk_zero("rst");
    @(negedge clk) rst = 1;
    repeat (20) tick();
    chk_zero("idle");
    force_lat = 2; force_rd_en = 1; force_rd = 16'hBEEF;
    b.i_addr = 16'h0040; b.i_req = 1;
    wait_ack(n);
    chk("i_lat", n, 4);
    chk("i_ack_dir", b.i_ack, 1);
    chk("i_rdata", b.rdata, 16'hBEEF);
    chk("i_hit", b.hit, 1);
    b.i_req = 0;
    tick();
    chk("acc_after_i", b.acc_cnt, 1);
    chk("hit_after_i", b.hit_cnt, 1);
    force_lat = 6; force_rd = 16'h5555;
    b.d_wr = 1; b.d_addr = 16'h1236; b.d_wdata = 16'hA5A5; b.d_req = 1;
    wait_ack(n);
    chk("d_lat", n, 8);
    chk("d_ack_dir", b.d_ack, 1);
    chk("d_hit", b.hit, 0);
    chk("d_rdata_kept", b.rdata, 16'hBEEF);
    b.d_req = 0;
    tick();
    chk("acc_after_d", b.acc_cnt, 2);
    chk("hit_after_d", b.hit_cnt, 1);
    force_lat = 2; force_rd_en = 0; glog.delete(); mode = 1;
    n = 0;
    while (glog.size() < 22 && n < 600) begin tick(); n++; end
    chk("starve_grants", glog.size() >= 22, 1);
    for (int k = 0; k < 10 && k < glog.size(); k++)
      chk("grant_order", glog[k], (k % 5) == 4 ? 0 : 1);
    drain();
    mode = 2; i_rel = 0; d_rel = 0; force_lat = 10;
    b.i_addr = 16'h0100; b.i_req = 1;
    tick(); tick();
    chk("pre_rst_busy", b.cache_rd, 1);
    #2 rst = 0;
    #1 chk_zero("rst_mid");
    b.i_req = 0;
    mreset();
    @(posedge clk);
    @(negedge clk) rst = 1;
    force_lat = 2; force_rd_en = 1; force_rd = 16'h1234;
    b.i_addr = 16'h0200; b.i_req = 1;
    wait_ack(n);
    chk("post_rst_lat", n, 4);
    chk("post_rst_i_ack", b.i_ack, 1);
    chk("post_rst_rdata", b.rdata, 16'h1234);
    b.i_req = 0;
    tick();
    chk("post_rst_acc", b.acc_cnt, 1);
    force_lat = 0; force_rd_en = 0; mode = 0;
    repeat (1500) tick();
    drain();
    repeat (3) tick();
    chk("acc_sat4", s.acc_cnt, 15);
    chk("hit_sat4", s.hit_cnt, 15);
    chk("acc_total", b.acc_cnt, sat(acc_m, 16));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 2-way set-associative cache controller between the instruction-fetch port (I, read-only) and the data-memory port (D, read/write).
- Selects one requester and latches its address, write data and direction.
- Holds the cache request stable until the cache signals Done, then returns the read data and a one-cycle ack to the winner.
- Tracks hit and access statistics. Sits between the fetch/memory pipeline stages and the cache controller.

Parameters:
- STARVE_MAX, 4: maximum consecutive D grants while I is waiting before I is forced to win (range 1..15).
- CNT_W, 16: width of the saturating statistics counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction read request; held until i_ack.
- i_addr  in  16  instruction address.
- d_req  in  1  data request; held until d_ack.
- d_wr  in  1  1 = write, 0 = read.
- d_addr  in  16  data address.
- d_wdata  in  16  data write value.
- i_ack  out  1  one-cycle completion pulse to I.
- d_ack  out  1  one-cycle completion pulse to D.
- rdata  out  16  read data; valid while i_ack or d_ack is high.
- hit  out  1  the completed access was a cache hit; valid with ack.
- i_stall  out  1  i_req & ~i_ack.
- d_stall  out  1  d_req & ~d_ack.
- cache_rd  out  1  read request to the cache.
- cache_wr  out  1  write request to the cache.
- cache_addr  out  16  latched address.
- cache_wdata  out  16  latched write data.
- cache_done  in  1  cache Done.
- cache_hit  in  1  cache CacheHit.
- cache_stall  in  1  cache Stall; 0 only while the cache is idle.
- cache_rdata  in  16  cache read data.
- acc_cnt  out  CNT_W  completed accesses, saturating.
- hit_cnt  out  CNT_W  completed hits, saturating.

Behaviour:
- Reset (rst low, async): state = IDLE.
  - Every output and register is 0: both acks, rdata, hit, cache_rd, cache_wr, cache_addr, cache_wdata, acc_cnt, hit_cnt.
  - Owner register = 0 (I), d_streak = 0.
  - Reset mid-transaction abandons it with no ack; the cache is reset by the same net.
- State machine: IDLE, BUSY, RESP.
- IDLE:
  - If cache_stall = 0 and any request is pending, pick the winner.
  - Latch owner, addr and wdata (the latter for D writes only), then go to BUSY.
  - Otherwise stay in IDLE.
- Arbitration: D has priority, except when i_req = 1 and d_streak = STARVE_MAX, in which case I wins.
- d_streak counter:
  - +1 on a D grant while i_req = 1.
  - Cleared on an I grant, and on a D grant while i_req = 0.
  - Never exceeds STARVE_MAX.
- BUSY:
  - cache_rd = ~latched_wr and cache_wr = latched_wr, held continuously every cycle. The cache samples the direction in its fill states, so it must not drop.
  - cache_addr and cache_wdata are held constant.
  - When cache_done = 1: capture cache_rdata into rdata (reads only; writes leave rdata unchanged), capture cache_hit into hit, then go to RESP.
- RESP (exactly one cycle):
  - cache_rd = cache_wr = 0. This guarantees the cache's idle cycle sees no request.
  - The owner's ack = 1.
  - acc_cnt += 1, and hit_cnt += hit; both saturate at all-ones.
  - Go to IDLE.
- cache_rd and cache_wr are 0 in IDLE and RESP. They are never both 1.
- Latency:
  - Request sampled in IDLE at cycle 0 → BUSY at cycle 1.
  - Cache hit: cache_done at cycle 3, ack at cycle 4.
  - Miss, clean victim: cache_done at cycle 7, ack at cycle 8.
  - Miss, dirty victim: cache_done at cycle 11, ack at cycle 12.
- Back-to-back: a requester may drop req in the cycle after its ack. A req still held at the IDLE following RESP is treated as a new request.
- Requests that change addr or data while not acked are ignored (the latched copy is used). Dropping req before ack is illegal; the transaction still completes and the ack is still pulsed.
- Simultaneous i_req and d_req with d_streak < STARVE_MAX: D wins, and I stalls until its turn.
- cache_done seen in IDLE or RESP is ignored.

Test Plan:
- Reset release, no requests → all outputs 0, cache_rd = cache_wr = 0 for 20 cycles.
- i_req, i_addr = 0x0040, cache model hits with rdata 0xBEEF:
  - cache_rd high in cycles 1-3.
  - i_ack at cycle 4 with rdata = 0xBEEF and hit = 1.
  - acc_cnt = 1, hit_cnt = 1.
- d_req, d_wr = 1, d_addr = 0x1236, d_wdata = 0xA5A5, clean miss:
  - cache_wr high with cache_wdata = 0xA5A5 until done at cycle 7.
  - d_ack at cycle 8, hit = 0, rdata unchanged.
- i_req and d_req held continuously, STARVE_MAX = 4, all hits → grant order D, D, D, D, I, D, D, D, D, I.
- Assert rst low during BUSY at cycle 2 → all outputs 0 immediately. After release, a fresh request completes normally with no stale ack.
- Force acc_cnt and hit_cnt to 0xFFFE, then issue 3 hits → both counters hold 0xFFFF.
